population_rate_counter: RTL and testbench

POPULATION_RATE_COUNTER -- requirements
Module: population_rate_counter

---
 rtl/population_rate_counter.sv | 127 ++++++++++++
 tb/tb_population_rate_counter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/population_rate_counter.sv
// Counts the fired neurons in a 128-bit population frame, one 8-bit slice per cycle,
// and sums the per-frame counts over a window of WIN_FRAMES frames.
module population_rate_counter #(
    parameter int unsigned WIN_FRAMES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pop_valid,
    input  logic [127:0] population,
    output logic         busy,
    output logic [7:0]   frame_count,
    output logic         frame_valid,
    output logic [15:0]  rate_out,
    output logic         rate_valid,
    output logic         overrun
);

    localparam int unsigned POP_W      = 128;
    localparam int unsigned SLICE_W    = 8;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned RATE_W     = 16;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned FIDX_W     = 8;
    localparam int unsigned LAST_SLICE = (POP_W / SLICE_W) - 1;
    localparam int unsigned LAST_FRAME = WIN_FRAMES - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [POP_W-1:0]    shreg;
    logic [CNT_W-1:0]    acc;
    logic [IDX_W-1:0]    slice_idx;
    logic [FIDX_W-1:0]   frame_idx;
    logic [RATE_W-1:0]   window_sum;
    logic [3:0]          slice_pc;
    logic                last_frame;
    logic [RATE_W-1:0]   frame_total;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the combinational helpers used by the datapath
    always_comb begin
        state_d     = state_q;
        slice_pc    = popcount8(shreg[SLICE_W-1:0]);
        last_frame  = (frame_idx == FIDX_W'(LAST_FRAME));
        frame_total = window_sum + RATE_W'(acc);
        case (state_q)
            IDLE:    if (pop_valid) state_d = COUNT;
            COUNT:   if (slice_idx == IDX_W'(LAST_SLICE)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg       <= '0;
            acc         <= '0;
            slice_idx   <= '0;
            frame_idx   <= '0;
            window_sum  <= '0;
            busy        <= 1'b0;
            frame_count <= '0;
            frame_valid <= 1'b0;
            rate_out    <= '0;
            rate_valid  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            rate_valid  <= 1'b0;
            busy        <= (state_d != IDLE);
            // A frame offered while one is still in flight is dropped
            if (pop_valid && (state_q != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (pop_valid) begin
                        shreg     <= population;
                        acc       <= '0;
                        slice_idx <= '0;
                    end
                end
                COUNT: begin
                    acc       <= acc + CNT_W'(slice_pc);
                    shreg     <= shreg >> SLICE_W;
                    slice_idx <= slice_idx + IDX_W'(1);
                end
                DONE: begin
                    frame_count <= acc;
                    frame_valid <= 1'b1;
                    if (last_frame) begin
                        rate_out   <= frame_total;
                        rate_valid <= 1'b1;
                        window_sum <= '0;
                        frame_idx  <= '0;
                    end else begin
                        window_sum <= frame_total;
                        frame_idx  <= frame_idx + FIDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_population_rate_counter.sv
// Directed bench for population_rate_counter: a 4-frame-window instance and a
// 256-frame-window instance share the stimulus.
module tb_population_rate_counter;

    logic         clk = 1'b0;
    logic         reset;
    logic         pop_valid;
    logic [127:0] population;

    logic         a_busy, a_frame_valid, a_rate_valid, a_overrun;
    logic [7:0]   a_frame_count;
    logic [15:0]  a_rate_out;
    logic         b_busy, b_frame_valid, b_rate_valid, b_overrun;
    logic [7:0]   b_frame_count;
    logic [15:0]  b_rate_out;

    always #5 clk = ~clk;

    population_rate_counter #(.WIN_FRAMES(4)) dut_w4 (
        .clk(clk), .reset(reset), .pop_valid(pop_valid), .population(population),
        .busy(a_busy), .frame_count(a_frame_count), .frame_valid(a_frame_valid),
        .rate_out(a_rate_out), .rate_valid(a_rate_valid), .overrun(a_overrun)
    );

    population_rate_counter #(.WIN_FRAMES(256)) dut_w256 (
        .clk(clk), .reset(reset), .pop_valid(pop_valid), .population(population),
        .busy(b_busy), .frame_count(b_frame_count), .frame_valid(b_frame_valid),
        .rate_out(b_rate_out), .rate_valid(b_rate_valid), .overrun(b_overrun)
    );

    typedef struct {
        logic [127:0] pop;
        int           exp_fc;
        bit           exp_rv;
        int           exp_ro;
    } vec_t;

    vec_t vecs [8];

    int n_cmp = 0;
    int n_err = 0;

    int           fv_cycle, fv_pulses, busy_cycles, rv_cycle, rvb_cycle;
    logic         busy_k18;
    logic [7:0]   fc_at;
    logic [15:0]  ro_at, rob_at;

    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] ALT  = {32{4'hA}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_frame(input logic [127:0] p);
        @(negedge clk);
        pop_valid  = 1'b1;
        population = p;
        @(negedge clk);
        pop_valid  = 1'b0;
    endtask

    // Observe 20 cycles after acceptance edge E; k is the cycle after edge E+k.
    // Optional extra pop_valid lands on edge E+inj_k+1, reset on edge E+rst_k+1.
    task automatic watch(input int inj_k, input logic [127:0] inj_p, input int rst_k);
        fv_cycle = -1; fv_pulses = 0; busy_cycles = 0; rv_cycle = -1; rvb_cycle = -1;
        busy_k18 = 1'b0; fc_at = '0; ro_at = '0; rob_at = '0;
        for (int k = 0; k < 20; k++) begin
            if (a_busy && k <= 17) busy_cycles++;
            if (k == 18) busy_k18 = a_busy;
            if (a_frame_valid) begin
                fv_pulses++;
                if (fv_cycle < 0) begin fv_cycle = k; fc_at = a_frame_count; end
            end
            if (a_rate_valid && rv_cycle < 0) begin rv_cycle = k; ro_at = a_rate_out; end
            if (b_rate_valid && rvb_cycle < 0) begin rvb_cycle = k; rob_at = b_rate_out; end
            pop_valid = (k == inj_k);
            if (k == inj_k) population = inj_p;
            reset = (k == rst_k);
            @(negedge clk);
        end
        pop_valid = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int exp_fc, input bit exp_rv, input int exp_ro);
        check({tag, "_fv_cycle"}, fv_cycle, 17);
        check({tag, "_fv_pulses"}, fv_pulses, 1);
        check({tag, "_busy_cycles"}, busy_cycles, 17);
        check({tag, "_frame_count"}, fc_at, exp_fc);
        check({tag, "_rv_cycle"}, rv_cycle, exp_rv ? 17 : -1);
        if (exp_rv) check({tag, "_rate_at_rv"}, ro_at, exp_ro);
        check({tag, "_rate_hold"}, a_rate_out, exp_ro);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int w;
        int early;

        vecs[0] = '{ONES,                 128, 1'b0,   0};
        vecs[1] = '{128'd0,                 0, 1'b0,   0};
        vecs[2] = '{ALT,                   64, 1'b0,   0};
        vecs[3] = '{128'd1,                 1, 1'b1, 193};
        vecs[4] = '{{1'b1, 127'd0},         1, 1'b0, 193};
        vecs[5] = '{{16{8'h0F}},           64, 1'b0, 193};
        vecs[6] = '{{8'hFF, 120'd0},        8, 1'b0, 193};
        vecs[7] = '{{32{4'h5}},            64, 1'b1, 137};

        reset = 1'b1; pop_valid = 1'b0; population = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", a_busy, 0);
        check("rst_frame_count", a_frame_count, 0);
        check("rst_frame_valid", a_frame_valid, 0);
        check("rst_rate_out", a_rate_out, 0);
        check("rst_rate_valid", a_rate_valid, 0);
        check("rst_overrun", a_overrun, 0);
        check("rst_w256_busy", b_busy, 0);

        // Reset and pop_valid on the same edge: frame must not start
        pop_valid = 1'b1; population = ONES;
        @(negedge clk);
        check("rst_pop_busy", a_busy, 0);
        reset = 1'b0; pop_valid = 1'b0;
        @(negedge clk);
        check("rst_pop_busy_after", a_busy, 0);

        for (int i = 0; i < 8; i++) begin
            start_frame(vecs[i].pop);
            watch(-1, '0, -1);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_fc, vecs[i].exp_rv, vecs[i].exp_ro);
        end
        check("vec_overrun_clear", a_overrun, 0);

        // Back-to-back at the minimum 18-cycle period
        start_frame(128'd0);
        watch(17, ONES, -1);
        check("e18_first_fc", fc_at, 0);
        check("e18_accepted_busy", busy_k18, 1);
        check("e18_no_overrun", a_overrun, 0);
        w = 0;
        while (!a_frame_valid && w < 30) begin
            @(negedge clk);
            w++;
        end
        check("e18_second_fv_delay", w, 15);
        check("e18_second_fc", a_frame_count, 128);
        repeat (3) @(negedge clk);

        // pop_valid on the DONE edge is dropped
        start_frame(ALT);
        watch(16, ONES, -1);
        check("e17_fc", fc_at, 64);
        check("e17_not_accepted", busy_k18, 0);
        check("e17_overrun", a_overrun, 1);
        do_reset();
        check("ovr_reset_clears", a_overrun, 0);

        // Second pop_valid at E+5 during COUNT
        start_frame(ALT);
        watch(4, ONES, -1);
        check("e5_fc", fc_at, 64);
        check("e5_fv_pulses", fv_pulses, 1);
        check("e5_busy_cycles", busy_cycles, 17);
        check("e5_not_accepted", busy_k18, 0);
        check("e5_overrun", a_overrun, 1);
        start_frame(128'd0);
        watch(-1, '0, -1);
        check("e5_overrun_sticky", a_overrun, 1);
        check("e5_clean_fc", fc_at, 0);
        do_reset();

        // Four sparse frames of alternating bits close a 4-frame window
        for (int f = 0; f < 4; f++) begin
            start_frame(ALT);
            watch(-1, '0, -1);
            check_frame($sformatf("win4_f%0d", f), 64, f == 3, (f == 3) ? 256 : 0);
            repeat (235) @(negedge clk);
        end
        start_frame(ALT);
        watch(-1, '0, -1);
        check_frame("win4_f4", 64, 1'b0, 256);

        // Reset in the middle of COUNT (edge E+8)
        start_frame(ONES);
        watch(-1, '0, 7);
        check("midrst_fv_pulses", fv_pulses, 0);
        check("midrst_busy", a_busy, 0);
        check("midrst_frame_count", a_frame_count, 0);
        check("midrst_frame_valid", a_frame_valid, 0);
        check("midrst_rate_out", a_rate_out, 0);
        check("midrst_rate_valid", a_rate_valid, 0);
        check("midrst_overrun", a_overrun, 0);
        for (int f = 0; f < 4; f++) begin
            start_frame(ONES);
            watch(-1, '0, -1);
            check_frame($sformatf("midrst_f%0d", f), 128, f == 3, (f == 3) ? 512 : 0);
        end

        // Full 256-frame window of all ones must reach 32768 without wrapping
        do_reset();
        early = 0;
        for (int f = 0; f < 256; f++) begin
            start_frame(ONES);
            watch(-1, '0, -1);
            if (f < 255 && rvb_cycle >= 0) early++;
        end
        check("w256_early_rate", early, 0);
        check("w256_rv_cycle", rvb_cycle, 17);
        check("w256_rate", rob_at, 32768);
        check("w256_fc", b_frame_count, 128);
        start_frame(ONES);
        watch(-1, '0, -1);
        check("w256_f257_no_rv", rvb_cycle, -1);
        check("w256_f257_rate_hold", b_rate_out, 32768);
        check("w256_f257_fc", b_frame_count, 128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
